load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory bus master between the control unit and the data bus. Accepts one-cycle load_data/store_data
//  pulses with ALU address, rs2 data and funct3; runs one valid/ready bus transaction; returns a one-cycle
//  data_valid pulse (the control unit's STATE_MEM exit) with sign/zero-extended load data for rd_din_sel=MEM.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles waiting on any bus channel before aborting with bus_err; 0 disables timeout
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset, synchronous, active-low
//  load_data      in   1   load request pulse (control unit, EXEC entry)
//  store_data     in   1   store request pulse
//  addr           in   32  byte address (ALU result)
//  wdata          in   32  store data (rs2)
//  funct          in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  data_valid     out  1   completion pulse, exactly one per accepted request
//  rdata          out  32  extended load result; held until next load completes
//  misaligned     out  1   pulse with data_valid: H at addr[0]=1 or W at addr[1:0]!=0
//  bus_err        out  1   pulse with data_valid: timeout abort
//  dr_addr/_valid/_ready     out32/out1/in1   read address channel (word aligned)
//  dr_data/_valid/_ready     in32/in1/out1    read data channel
//  dw_addr/_data/_strobe/_valid/_ready  out32/out32/out4/out1/in1  write channel
//  dw_resp_valid/_ready      in1/out1         write response channel
// BEHAVIOUR
//  Reset: state IDLE; data_valid, misaligned, bus_err, all *_valid, *_ready, rdata, dw_strobe = 0.
//  Request capture in IDLE: addr, wdata, funct registered. load_data&store_data together -> load served,
//   store dropped. Requests outside IDLE ignored (control unit never issues them; bench asserts).
//  FSM: IDLE -load-> RD_ADDR -dr_addr_ready-> RD_DATA -dr_data_valid-> DONE -> IDLE
//       IDLE -store-> WR -dw_ready-> WR_RESP -dw_resp_valid-> DONE -> IDLE
//       IDLE -misaligned req-> DONE (no bus activity, misaligned=1, rdata unchanged)
//  Handshakes: *_valid rises the cycle after capture, held with stable payload until ready; transfer on
//   valid&ready same edge. dr_data_ready, dw_resp_ready asserted only in RD_DATA/WR_RESP.
//  Latency (zero-wait bus): request at cycle N -> data_valid at N+3. data_valid driven only in DONE,
//   exactly 1 cycle; rdata valid in same cycle.
//  Addressing: dr_addr/dw_addr = {addr[31:2],2'b00}. Lane off = addr[1:0].
//   Store: data replicated per size (B: {4{b}}, H: {2{h}}); strobe B=4'b0001<<off, H=4'b0011<<off, W=4'hF.
//   Load: byte/half selected by off, sign-extended (000/001) or zero-extended (100/101); W passthrough.
//   Undefined funct (011,11x): treated as W.
//  Timeout: cycle counter cleared on every state entry; in RD_ADDR/RD_DATA/WR/WR_RESP, reaching
//   TIMEOUT_CYCLES -> drop *_valid/_ready, go DONE with bus_err=1, rdata unchanged. Late bus beats ignored.
//  Reset mid-transaction: immediate return to IDLE, all valids deasserted next edge, no data_valid.
// STRUCTURE
//  copperv_h.v: LSU_STATE_* encodings, FUNCT_MEM_{B,H,W,BU,HU}, STROBE widths.
//  Sub-module lsu_align (combinational): store replicate+strobe and load extract+extend; FSM in top.
// TESTING
//  LW addr 0x100, zero-wait, mem=0xDEADBEEF -> dr_addr 0x100, data_valid at N+3, rdata 0xDEADBEEF.
//  LB addr 0x103 mem 0x80FF_FFFF -> rdata 0xFFFFFF80; LBU same -> 0x00000080; LHU 0x102 -> 0x000080FF.
//  SH addr 0x202 wdata 0x1234ABCD -> dw_addr 0x200, dw_data 0xABCDABCD, strobe 4'b1100.
//  dr_addr_ready held low 5 cycles then high -> dr_addr_valid and dr_addr stable throughout; one data_valid.
//  LW addr 0x101 -> misaligned=1 with data_valid at N+1, no dr_addr_valid ever asserted.
//  TIMEOUT_CYCLES=8, no dw_resp_valid -> bus_err+data_valid after 8 WR_RESP cycles; rst low in RD_DATA -> IDLE.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: FSM states, RV32 memory funct3 codes
// and the access-size decode used by both the FSM and the lane aligner.
package load_store_unit_pkg;

   typedef enum logic [2:0] {
      LSU_STATE_IDLE,
      LSU_STATE_RD_ADDR,
      LSU_STATE_RD_DATA,
      LSU_STATE_WR,
      LSU_STATE_WR_RESP,
      LSU_STATE_DONE
   } lsu_state_e;

   typedef enum logic [1:0] {
      SIZE_B,
      SIZE_H,
      SIZE_W
   } mem_size_e;

   localparam logic [2:0] FUNCT_MEM_B  = 3'b000;
   localparam logic [2:0] FUNCT_MEM_H  = 3'b001;
   localparam logic [2:0] FUNCT_MEM_W  = 3'b010;
   localparam logic [2:0] FUNCT_MEM_BU = 3'b100;
   localparam logic [2:0] FUNCT_MEM_HU = 3'b101;

   localparam int STROBE_WIDTH = 4;

   // Undefined codes (011, 11x) fall through to a full-word access.
   function automatic mem_size_e funct_size(input logic [2:0] f);
      case (f[1:0])
         FUNCT_MEM_B[1:0]: return SIZE_B;
         FUNCT_MEM_H[1:0]: return SIZE_H;
         default:          return SIZE_W;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: store replication and strobe generation on the
// request side, byte/half extraction with sign or zero extension on the load side.
import load_store_unit_pkg::*;

module load_store_unit_align (
   input  logic [2:0]              req_funct,
   input  logic [1:0]              req_off,
   input  logic [31:0]             wdata,
   output logic [31:0]             st_data,
   output logic [STROBE_WIDTH-1:0] st_strobe,
   output logic                    req_misaligned,
   input  logic [2:0]              ld_funct,
   input  logic [1:0]              ld_off,
   input  logic [31:0]             raw,
   output logic [31:0]             ld_result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      st_data        = wdata;
      st_strobe      = 4'hF;
      req_misaligned = 1'b0;
      case (funct_size(req_funct))
         SIZE_B: begin
            st_data   = {4{wdata[7:0]}};
            st_strobe = 4'b0001 << req_off;
         end
         SIZE_H: begin
            st_data        = {2{wdata[15:0]}};
            st_strobe      = 4'b0011 << req_off;
            req_misaligned = req_off[0];
         end
         default: begin
            req_misaligned = |req_off;
         end
      endcase
   end

   // funct3 bit 2 marks the unsigned variants (LBU/LHU).
   always_comb begin
      case (ld_off)
         2'd0:    byte_sel = raw[7:0];
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         default: byte_sel = raw[31:24];
      endcase
      half_sel  = ld_off[1] ? raw[31:16] : raw[15:0];
      ld_result = raw;
      case (funct_size(ld_funct))
         SIZE_B:  ld_result = ld_funct[2] ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SIZE_H:  ld_result = ld_funct[2] ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_result = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory bus master: turns one load/store pulse into a single valid/ready
// bus transaction and answers with a one-cycle data_valid completion pulse.
import load_store_unit_pkg::*;

module load_store_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_data,
   input  logic                    store_data,
   input  logic [31:0]             addr,
   input  logic [31:0]             wdata,
   input  logic [2:0]              funct,
   output logic                    data_valid,
   output logic [31:0]             rdata,
   output logic                    misaligned,
   output logic                    bus_err,
   output logic [31:0]             dr_addr,
   output logic                    dr_addr_valid,
   input  logic                    dr_addr_ready,
   input  logic [31:0]             dr_data,
   input  logic                    dr_data_valid,
   output logic                    dr_data_ready,
   output logic [31:0]             dw_addr,
   output logic [31:0]             dw_data,
   output logic [STROBE_WIDTH-1:0] dw_strobe,
   output logic                    dw_valid,
   input  logic                    dw_ready,
   input  logic                    dw_resp_valid,
   output logic                    dw_resp_ready
);

   lsu_state_e              state;
   logic [31:0]             bus_addr;
   logic [31:0]             wait_cnt;
   logic [2:0]              funct_q;
   logic [1:0]              off_q;
   logic [31:0]             st_data;
   logic [STROBE_WIDTH-1:0] st_strobe;
   logic                    req_mis;
   logic [31:0]             ld_result;
   logic                    bus_wait;
   logic                    bus_fire;
   logic                    tmo_hit;

   load_store_unit_align u_align (
      .req_funct      (funct),
      .req_off        (addr[1:0]),
      .wdata          (wdata),
      .st_data        (st_data),
      .st_strobe      (st_strobe),
      .req_misaligned (req_mis),
      .ld_funct       (funct_q),
      .ld_off         (off_q),
      .raw            (dr_data),
      .ld_result      (ld_result)
   );

   assign dr_addr = bus_addr;
   assign dw_addr = bus_addr;

   always_comb begin
      bus_wait = 1'b1;
      bus_fire = 1'b0;
      case (state)
         LSU_STATE_RD_ADDR: bus_fire = dr_addr_ready;
         LSU_STATE_RD_DATA: bus_fire = dr_data_valid;
         LSU_STATE_WR:      bus_fire = dw_ready;
         LSU_STATE_WR_RESP: bus_fire = dw_resp_valid;
         default:           bus_wait = 1'b0;
      endcase
   end

   // A beat that lands on the final allowed cycle still wins over the abort.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= LSU_STATE_IDLE;
         data_valid    <= 1'b0;
         misaligned    <= 1'b0;
         bus_err       <= 1'b0;
         rdata         <= '0;
         dr_addr_valid <= 1'b0;
         dr_data_ready <= 1'b0;
         dw_valid      <= 1'b0;
         dw_resp_ready <= 1'b0;
         dw_data       <= '0;
         dw_strobe     <= '0;
         bus_addr      <= '0;
         funct_q       <= '0;
         off_q         <= '0;
         wait_cnt      <= '0;
      end else begin
         data_valid <= 1'b0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         wait_cnt   <= wait_cnt + 32'd1;
         if (bus_wait && !bus_fire && tmo_hit) begin
            dr_addr_valid <= 1'b0;
            dr_data_ready <= 1'b0;
            dw_valid      <= 1'b0;
            dw_resp_ready <= 1'b0;
            data_valid    <= 1'b1;
            bus_err       <= 1'b1;
            wait_cnt      <= '0;
            state         <= LSU_STATE_DONE;
         end else begin
            case (state)
               LSU_STATE_IDLE: begin
                  wait_cnt <= '0;
                  if (load_data || store_data) begin
                     funct_q  <= funct;
                     off_q    <= addr[1:0];
                     bus_addr <= {addr[31:2], 2'b00};
                     if (req_mis) begin
                        data_valid <= 1'b1;
                        misaligned <= 1'b1;
                        state      <= LSU_STATE_DONE;
                     end else if (load_data) begin
                        dr_addr_valid <= 1'b1;
                        state         <= LSU_STATE_RD_ADDR;
                     end else begin
                        dw_valid  <= 1'b1;
                        dw_data   <= st_data;
                        dw_strobe <= st_strobe;
                        state     <= LSU_STATE_WR;
                     end
                  end
               end
               LSU_STATE_RD_ADDR: if (bus_fire) begin
                  dr_addr_valid <= 1'b0;
                  dr_data_ready <= 1'b1;
                  wait_cnt      <= '0;
                  state         <= LSU_STATE_RD_DATA;
               end
               LSU_STATE_RD_DATA: if (bus_fire) begin
                  dr_data_ready <= 1'b0;
                  rdata         <= ld_result;
                  data_valid    <= 1'b1;
                  wait_cnt      <= '0;
                  state         <= LSU_STATE_DONE;
               end
               LSU_STATE_WR: if (bus_fire) begin
                  dw_valid      <= 1'b0;
                  dw_resp_ready <= 1'b1;
                  wait_cnt      <= '0;
                  state         <= LSU_STATE_WR_RESP;
               end
               LSU_STATE_WR_RESP: if (bus_fire) begin
                  dw_resp_ready <= 1'b0;
                  data_valid    <= 1'b1;
                  wait_cnt      <= '0;
                  state         <= LSU_STATE_DONE;
               end
               default: begin
                  wait_cnt <= '0;
                  state    <= LSU_STATE_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads/stores against a small bus
// responder, with completions checked by an independent data_valid monitor.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int unsigned TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        load_data = 1'b0;
   logic        store_data = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [2:0]  funct = '0;
   logic        data_valid;
   logic [31:0] rdata;
   logic        misaligned;
   logic        bus_err;
   logic [31:0] dr_addr;
   logic        dr_addr_valid;
   logic        dr_addr_ready;
   logic [31:0] dr_data;
   logic        dr_data_valid;
   logic        dr_data_ready;
   logic [31:0] dw_addr;
   logic [31:0] dw_data;
   logic [3:0]  dw_strobe;
   logic        dw_valid;
   logic        dw_ready;
   logic        dw_resp_valid;
   logic        dw_resp_ready;

   load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .load_data(load_data), .store_data(store_data),
      .addr(addr), .wdata(wdata), .funct(funct),
      .data_valid(data_valid), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
      .dr_addr(dr_addr), .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready),
      .dr_data(dr_data), .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready),
      .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe), .dw_valid(dw_valid),
      .dw_ready(dw_ready), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        mis;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   // Knobs written only by the stimulus process
   int          addr_delay = 0;
   bit          rd_data_en = 1'b1;
   bit          resp_en = 1'b1;
   logic [31:0] mem_word = '0;

   // Monotonic observations written only by the responder
   int          hold = 0;
   bit          in_rd = 1'b0;
   logic [31:0] held_addr = '0;
   int          rd_unstable_total = 0;
   int          rd_valid_total = 0;
   int          dw_valid_total = 0;
   logic [31:0] last_rd_addr = '0;
   logic [31:0] last_dw_addr = '0;
   logic [31:0] last_dw_data = '0;
   logic [3:0]  last_dw_strobe = '0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
      end
   endtask

   // Bus slave: programmable read-address stall, otherwise zero-wait
   always @(negedge clk) begin
      if (dr_addr_valid) begin
         if (!in_rd) begin
            held_addr = dr_addr;
            in_rd     = 1'b1;
         end else if (dr_addr !== held_addr) begin
            rd_unstable_total++;
         end
         rd_valid_total++;
         dr_addr_ready = (hold >= addr_delay);
         hold++;
         if (dr_addr_ready) last_rd_addr = dr_addr;
      end else begin
         in_rd         = 1'b0;
         hold          = 0;
         dr_addr_ready = 1'b0;
      end
      dr_data       = mem_word;
      dr_data_valid = rd_data_en;
      dw_ready      = 1'b1;
      dw_resp_valid = resp_en;
      if (dw_valid) begin
         dw_valid_total++;
         last_dw_addr   = dw_addr;
         last_dw_data   = dw_data;
         last_dw_strobe = dw_strobe;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst && data_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_data_valid: got 1 at cycle %0d, expected 0", cyc);
         end else begin
            e = sb.pop_front();
            checkOutput({e.name, "_rdata"}, rdata, e.rdata);
            checkOutput({e.name, "_misaligned"}, {31'b0, misaligned}, {31'b0, e.mis});
            checkOutput({e.name, "_bus_err"}, {31'b0, bus_err}, {31'b0, e.err});
            checkOutput({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic applyStimulus(input bit ld, input bit st, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f, input string name,
                                input logic [31:0] er, input bit em, input bit ee,
                                input int lat, input bit expect_done);
      exp_t e;
      @(posedge clk);
      #1;
      load_data  = ld;
      store_data = st;
      addr       = a;
      wdata      = wd;
      funct      = f;
      if (expect_done) begin
         e.name  = name;
         e.rdata = er;
         e.mis   = em;
         e.err   = ee;
         e.cyc   = cyc + lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      load_data  = 1'b0;
      store_data = 1'b0;
   endtask

   task automatic waitDone(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         tests++;
         fails++;
         $display("[TB] FAIL %s_wait: got no data_valid within 40 cycles, expected one", name);
         sb.delete();
      end
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rv;
      int dv;
      int un;

      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ctrl",
                  {25'b0, data_valid, misaligned, bus_err, dr_addr_valid, dr_data_ready, dw_valid, dw_resp_ready},
                  32'h0);
      checkOutput("reset_rdata", rdata, 32'h0);
      checkOutput("reset_strobe", {28'b0, dw_strobe}, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      mem_word = 32'hDEADBEEF;
      applyStimulus(1, 0, 32'h100, 0, FUNCT_MEM_W, "lw", 32'hDEADBEEF, 0, 0, 3, 1);
      waitDone("lw");
      checkOutput("lw_dr_addr", last_rd_addr, 32'h100);

      mem_word = 32'h80FFFFFF;
      applyStimulus(1, 0, 32'h103, 0, FUNCT_MEM_B, "lb", 32'hFFFFFF80, 0, 0, 3, 1);
      waitDone("lb");
      checkOutput("lb_dr_addr", last_rd_addr, 32'h100);
      applyStimulus(1, 0, 32'h103, 0, FUNCT_MEM_BU, "lbu", 32'h00000080, 0, 0, 3, 1);
      waitDone("lbu");
      applyStimulus(1, 0, 32'h102, 0, FUNCT_MEM_HU, "lhu", 32'h000080FF, 0, 0, 3, 1);
      waitDone("lhu");
      applyStimulus(1, 0, 32'h102, 0, FUNCT_MEM_H, "lh", 32'hFFFF80FF, 0, 0, 3, 1);
      waitDone("lh");

      mem_word = 32'h11223344;
      applyStimulus(1, 0, 32'h101, 0, FUNCT_MEM_B, "lb_off1", 32'h00000033, 0, 0, 3, 1);
      waitDone("lb_off1");

      applyStimulus(0, 1, 32'h202, 32'h1234ABCD, FUNCT_MEM_H, "sh", 32'h00000033, 0, 0, 3, 1);
      waitDone("sh");
      checkOutput("sh_dw_addr", last_dw_addr, 32'h200);
      checkOutput("sh_dw_data", last_dw_data, 32'hABCDABCD);
      checkOutput("sh_dw_strobe", {28'b0, last_dw_strobe}, 32'hC);

      applyStimulus(0, 1, 32'h201, 32'h000000A5, FUNCT_MEM_B, "sb", 32'h00000033, 0, 0, 3, 1);
      waitDone("sb");
      checkOutput("sb_dw_data", last_dw_data, 32'hA5A5A5A5);
      checkOutput("sb_dw_strobe", {28'b0, last_dw_strobe}, 32'h2);

      applyStimulus(0, 1, 32'h204, 32'hCAFEF00D, FUNCT_MEM_W, "sw", 32'h00000033, 0, 0, 3, 1);
      waitDone("sw");
      checkOutput("sw_dw_addr", last_dw_addr, 32'h204);
      checkOutput("sw_dw_data", last_dw_data, 32'hCAFEF00D);
      checkOutput("sw_dw_strobe", {28'b0, last_dw_strobe}, 32'hF);

      // Read-address channel stalled for five cycles
      mem_word   = 32'hDEADBEEF;
      addr_delay = 5;
      rv = rd_valid_total;
      un = rd_unstable_total;
      applyStimulus(1, 0, 32'h100, 0, FUNCT_MEM_W, "lw_stall", 32'hDEADBEEF, 0, 0, 8, 1);
      waitDone("lw_stall");
      addr_delay = 0;
      checkOutput("lw_stall_valid_cycles", 32'(rd_valid_total - rv), 32'd6);
      checkOutput("lw_stall_unstable", 32'(rd_unstable_total - un), 32'd0);
      checkOutput("lw_stall_dr_addr", last_rd_addr, 32'h100);

      rv = rd_valid_total;
      applyStimulus(1, 0, 32'h101, 0, FUNCT_MEM_W, "lw_mis", 32'hDEADBEEF, 1, 0, 1, 1);
      waitDone("lw_mis");
      checkOutput("lw_mis_no_bus", 32'(rd_valid_total - rv), 32'd0);

      dv = dw_valid_total;
      applyStimulus(0, 1, 32'h203, 32'h55667788, FUNCT_MEM_H, "sh_mis", 32'hDEADBEEF, 1, 0, 1, 1);
      waitDone("sh_mis");
      checkOutput("sh_mis_no_bus", 32'(dw_valid_total - dv), 32'd0);

      mem_word = 32'h0BADF00D;
      dv = dw_valid_total;
      applyStimulus(1, 1, 32'h100, 32'h99999999, FUNCT_MEM_W, "ld_st_both", 32'h0BADF00D, 0, 0, 3, 1);
      waitDone("ld_st_both");
      checkOutput("ld_st_both_no_store", 32'(dw_valid_total - dv), 32'd0);

      // Write response never arrives: aborted after TMO cycles in WR_RESP
      resp_en = 1'b0;
      applyStimulus(0, 1, 32'h208, 32'h01020304, FUNCT_MEM_W, "sw_timeout", 32'h0BADF00D, 0, 1, 10, 1);
      waitDone("sw_timeout");
      checkOutput("sw_timeout_resp_ready", {31'b0, dw_resp_ready}, 32'h0);
      resp_en = 1'b1;

      // Reset while waiting for read data
      rd_data_en = 1'b0;
      applyStimulus(1, 0, 32'h100, 0, FUNCT_MEM_W, "rst_mid", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      checkOutput("rst_mid_in_rd_data", {31'b0, dr_data_ready}, 32'h1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      checkOutput("rst_mid_ctrl", {29'b0, dr_addr_valid, dr_data_ready, data_valid}, 32'h0);
      checkOutput("rst_mid_rdata", rdata, 32'h0);
      rd_data_en = 1'b1;
      repeat (4) @(posedge clk);

      mem_word = 32'h13579BDF;
      applyStimulus(1, 0, 32'h104, 0, 3'b011, "lw_undef_funct", 32'h13579BDF, 0, 0, 3, 1);
      waitDone("lw_undef_funct");
      checkOutput("lw_undef_funct_dr_addr", last_rd_addr, 32'h104);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
